// File: rtl/mips_exec_pkg.sv
// mips_exec_pkg: shared constants for the MIPS execute slice.
//   - alu_op_e : 4-bit ALU operation codes driven on alu_op
//   - Op*      : instruction[31:26] opcode values the decoder recognises
//   - Fn*      : R-type instruction[5:0] funct values the decoder recognises
package mips_exec_pkg;

    typedef enum logic [3:0] {
        AluAnd  = 4'b0000,
        AluOr   = 4'b0001,
        AluAdd  = 4'b0010,
        AluSub  = 4'b0110,
        AluSlt  = 4'b0111,
        AluSll  = 4'b1000,
        AluSrl  = 4'b1001,
        AluSltu = 4'b1010,
        AluLui  = 4'b1011,
        AluNor  = 4'b1100
    } alu_op_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLb    = 6'h20;
    localparam logic [5:0] OpLh    = 6'h21;
    localparam logic [5:0] OpLwl   = 6'h22;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpLbu   = 6'h24;
    localparam logic [5:0] OpLhu   = 6'h25;
    localparam logic [5:0] OpSb    = 6'h28;
    localparam logic [5:0] OpSh    = 6'h29;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps opcode/funct to an ALU operation and selects the
// immediate extension type. Purely combinational.
//   opcode_i   : instruction[31:26]
//   funct_i    : instruction[5:0], only meaningful for R-type
//   alu_op_o   : decoded ALU operation
//   zero_ext_o : 1 = zero-extend imm16, 0 = sign-extend
module mips_alu_decoder
    import mips_exec_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output alu_op_e    alu_op_o,
    output logic       zero_ext_o
);

    always_comb begin
        alu_op_o = AluAdd;
        if (opcode_i == OpRtype) begin
            case (funct_i)
                FnAdd, FnAddu: alu_op_o = AluAdd;
                FnSub, FnSubu: alu_op_o = AluSub;
                FnAnd:         alu_op_o = AluAnd;
                FnOr:          alu_op_o = AluOr;
                FnNor:         alu_op_o = AluNor;
                FnSlt:         alu_op_o = AluSlt;
                FnSltu:        alu_op_o = AluSltu;
                FnSll:         alu_op_o = AluSll;
                FnSrl:         alu_op_o = AluSrl;
                default:       alu_op_o = AluAdd;
            endcase
        end else begin
            case (opcode_i)
                OpAddi, OpAddiu,
                OpLb, OpLh, OpLwl, OpLw, OpLbu, OpLhu,
                OpSb, OpSh, OpSw: alu_op_o = AluAdd;
                OpBeq, OpBne:     alu_op_o = AluSub;
                OpAndi:           alu_op_o = AluAnd;
                OpOri:            alu_op_o = AluOr;
                OpSlti:           alu_op_o = AluSlt;
                OpSltiu:          alu_op_o = AluSltu;
                OpLui:            alu_op_o = AluLui;
                default:          alu_op_o = AluAdd;
            endcase
        end
    end

    // Only the logical immediates treat imm16 as unsigned.
    assign zero_ext_o = (opcode_i == OpAndi) || (opcode_i == OpOri);

endmodule

// File: rtl/mips_exec_core.sv
// mips_exec_core: 32x32 register file plus ALU decode and execute.
//   clk, rst_n          : clock; async active-low reset clears all registers
//   opcode/funct/shamt  : instruction fields feeding the decoder and shifter
//   rs_addr/rt_addr     : combinational read addresses -> rd_data1/rd_data2
//   imm16, alu_src      : immediate and operand-B select (1 = extended imm)
//   wr_en/wr_addr/wr_data : synchronous write port (reg 0 writes dropped)
//   alu_op/alu_result/alu_zero : decoded op, result, result-is-zero flag
module mips_exec_core
    import mips_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [15:0] imm16,
    input  logic        alu_src,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_result,
    output logic        alu_zero
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // No write bypass: reads always see the stored value.
    assign rd_data1 = (rs_addr == 5'd0) ? 32'd0 : regs_q[rs_addr];
    assign rd_data2 = (rt_addr == 5'd0) ? 32'd0 : regs_q[rt_addr];

    alu_op_e op;
    logic    zero_ext;

    mips_alu_decoder u_dec (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_op_o   (op),
        .zero_ext_o (zero_ext)
    );

    assign alu_op = op;

    logic [31:0] ext_imm;
    logic [31:0] opa;
    logic [31:0] opb;

    assign ext_imm = zero_ext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
    // Shifts take their amount from shamt and shift operand B.
    assign opa = ((op == AluSll) || (op == AluSrl)) ? {27'd0, shamt} : rd_data1;
    assign opb = alu_src ? ext_imm : rd_data2;

    always_comb begin
        alu_result = opa + opb;
        case (op)
            AluAnd:  alu_result = opa & opb;
            AluOr:   alu_result = opa | opb;
            AluAdd:  alu_result = opa + opb;
            AluSub:  alu_result = opa - opb;
            AluSlt:  alu_result = {31'd0, $signed(opa) < $signed(opb)};
            AluSltu: alu_result = {31'd0, opa < opb};
            AluNor:  alu_result = ~(opa | opb);
            AluSll:  alu_result = opb << opa[4:0];
            AluSrl:  alu_result = opb >> opa[4:0];
            AluLui:  alu_result = {opb[15:0], 16'd0};
            default: alu_result = opa + opb;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

endmodule

// File: tb/tb_mips_exec_core.sv
// Self-checking bench for mips_exec_core: directed literal checks plus a
// randomized run compared every negative clock edge against a reference model.
module tb_mips_exec_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [15:0] imm16 = '0;
    logic        alu_src = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    mips_exec_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .shamt      (shamt),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .imm16      (imm16),
        .alu_src    (alu_src),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mreg [32];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mreg[i] <= '0;
        end else if (wr_en && wr_addr != 5'd0) begin
            mreg[wr_addr] <= wr_data;
        end
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) mreg[i] <= '0;
    end

    function automatic logic [31:0] mrd(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        return mreg[a];
    endfunction

    function automatic logic [3:0] model_op(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: return 4'b0010;
                6'h22, 6'h23: return 4'b0110;
                6'h24: return 4'b0000;
                6'h25: return 4'b0001;
                6'h27: return 4'b1100;
                6'h2A: return 4'b0111;
                6'h2B: return 4'b1010;
                6'h00: return 4'b1000;
                6'h02: return 4'b1001;
                default: return 4'b0010;
            endcase
        end
        case (op)
            6'h04, 6'h05: return 4'b0110;
            6'h0C: return 4'b0000;
            6'h0D: return 4'b0001;
            6'h0A: return 4'b0111;
            6'h0B: return 4'b1010;
            6'h0F: return 4'b1011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [31:0] model_res(input logic [3:0] code, input logic [5:0] op,
                                              input logic [4:0] sa, input logic [31:0] rs_v,
                                              input logic [31:0] rt_v, input logic [15:0] imm,
                                              input logic src);
        logic [31:0] ext;
        logic [31:0] b;
        if (op == 6'h0C || op == 6'h0D) ext = {16'd0, imm};
        else ext = {{16{imm[15]}}, imm};
        b = src ? ext : rt_v;
        case (code)
            4'b0000: return rs_v & b;
            4'b0001: return rs_v | b;
            4'b0110: return rs_v - b;
            4'b0111: return ($signed(rs_v) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1010: return (rs_v < b) ? 32'd1 : 32'd0;
            4'b1100: return ~(rs_v | b);
            4'b1000: return b << sa;
            4'b1001: return b >> sa;
            4'b1011: return {b[15:0], 16'd0};
            default: return rs_v + b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are combinational, so every cycle is meaningful.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]  eop;
            logic [31:0] eres;
            eop  = model_op(opcode, funct);
            eres = model_res(eop, opcode, shamt, mrd(rs_addr), mrd(rt_addr), imm16, alu_src);
            chk("rd_data1", rd_data1, mrd(rs_addr));
            chk("rd_data2", rd_data2, mrd(rt_addr));
            chk("alu_op", {28'd0, alu_op}, {28'd0, eop});
            chk("alu_result", alu_result, eres);
            chk("alu_zero", {31'd0, alu_zero}, {31'd0, eres == 32'd0});
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        next();
        wr_en = 1'b0;
    endtask

    task automatic setop(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [15:0] imm, input logic src);
        opcode = op;
        funct = fn;
        rs_addr = rs;
        rt_addr = rt;
        imm16 = imm;
        alu_src = src;
        #1;
    endtask

    logic [5:0] op_pool [19] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h20, 6'h23, 6'h25, 6'h28,
                                 6'h2B, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0A, 6'h0B, 6'h0F, 6'h3F,
                                 6'h11};
    logic [5:0] fn_pool [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                                 6'h00, 6'h02, 6'h08, 6'h3F};
    logic [31:0] data_pool [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,
                                   32'h0000_FFFF};

    initial begin
        // Reset: all registers read 0 on both ports.
        next();
        next();
        chk_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs_addr = i[4:0];
            rt_addr = 5'(31 - i);
            #1;
            chk("reset_rd1", rd_data1, 32'd0);
            chk("reset_rd2", rd_data2, 32'd0);
        end
        rst_n = 1'b1;
        next();

        wr(5'd0, 32'hDEAD_BEEF);
        setop(6'h00, 6'h20, 5'd0, 5'd0, 16'h0, 1'b0);
        chk("reg0_rd1", rd_data1, 32'd0);
        chk("reg0_rd2", rd_data2, 32'd0);

        // addi sequence
        setop(6'h08, 6'h00, 5'd0, 5'd0, 16'd2, 1'b1);
        chk("addi_2", alu_result, 32'd2);
        wr(5'd16, 32'd2);
        setop(6'h08, 6'h00, 5'd16, 5'd0, 16'd3, 1'b1);
        chk("addi_5", alu_result, 32'd5);
        wr(5'd16, 32'd5);
        chk("addi_wb", rd_data1, 32'd5);

        // R-type with A = -1, B = 1
        wr(5'd1, 32'hFFFF_FFFF);
        wr(5'd2, 32'd1);
        setop(6'h00, 6'h20, 5'd1, 5'd2, 16'h0, 1'b0);
        chk("add", alu_result, 32'd0);
        chk("add_zero", {31'd0, alu_zero}, 32'd1);
        setop(6'h00, 6'h22, 5'd1, 5'd2, 16'h0, 1'b0);
        chk("sub", alu_result, 32'hFFFF_FFFE);
        setop(6'h00, 6'h2A, 5'd1, 5'd2, 16'h0, 1'b0);
        chk("slt", alu_result, 32'd1);
        setop(6'h00, 6'h2B, 5'd1, 5'd2, 16'h0, 1'b0);
        chk("sltu", alu_result, 32'd0);
        setop(6'h00, 6'h27, 5'd1, 5'd2, 16'h0, 1'b0);
        chk("nor", alu_result, 32'd0);

        // Shifts and immediates
        wr(5'd3, 32'h0000_000F);
        wr(5'd4, 32'h8000_0000);
        wr(5'd8, 32'd8);
        shamt = 5'd4;
        setop(6'h00, 6'h00, 5'd1, 5'd3, 16'h0, 1'b0);
        chk("sll", alu_result, 32'h0000_00F0);
        setop(6'h00, 6'h02, 5'd1, 5'd4, 16'h0, 1'b0);
        chk("srl", alu_result, 32'h0800_0000);
        setop(6'h0F, 6'h00, 5'd0, 5'd0, 16'h1234, 1'b1);
        chk("lui", alu_result, 32'h1234_0000);
        setop(6'h0C, 6'h00, 5'd1, 5'd0, 16'hFFFF, 1'b1);
        chk("andi", alu_result, 32'h0000_FFFF);

        // Branch and memory
        setop(6'h04, 6'h00, 5'd2, 5'd2, 16'h0, 1'b0);
        chk("beq_op", {28'd0, alu_op}, 32'h6);
        chk("beq_zero", {31'd0, alu_zero}, 32'd1);
        setop(6'h23, 6'h00, 5'd8, 5'd0, 16'hFFFC, 1'b1);
        chk("lw", alu_result, 32'd4);

        // Read during write: old value before the edge, new after.
        rs_addr = 5'd3;
        wr_en = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'd7;
        #1;
        chk("rdw_old", rd_data1, 32'h0000_000F);
        next();
        wr_en = 1'b0;
        chk("rdw_new", rd_data1, 32'd7);

        // Randomized run with occasional reset pulses.
        for (int n = 0; n < 1500; n++) begin
            opcode  = op_pool[$urandom_range(0, 18)];
            funct   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 12)];
            shamt   = 5'($urandom);
            rs_addr = 5'($urandom_range(0, 9));
            rt_addr = 5'($urandom_range(0, 9));
            imm16   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            alu_src = 1'($urandom);
            wr_en   = 1'($urandom);
            wr_addr = 5'($urandom_range(0, 9));
            wr_data = ($urandom_range(0, 1) == 0) ? data_pool[$urandom_range(0, 5)] : $urandom;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 63) == 0) rst_n = 1'b0;
            next();
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        next();

        // Asynchronous reset mid-cycle clears without a clock edge.
        wr(5'd5, 32'h55);
        wr(5'd6, 32'h66);
        setop(6'h00, 6'h25, 5'd5, 5'd6, 16'h0, 1'b0);
        chk("pre_rst_rd1", rd_data1, 32'h55);
        chk("pre_rst_rd2", rd_data2, 32'h66);
        rst_n = 1'b0;
        #1;
        chk("async_rd1", rd_data1, 32'd0);
        chk("async_rd2", rd_data2, 32'd0);
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h99;
        next();
        chk("rst_wr_ignored", rd_data1, 32'd0);
        rst_n = 1'b1;
        next();
        wr_en = 1'b0;
        chk("post_rst_wr", rd_data1, 32'h99);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_exec_core.md
# mips_exec_core

Combined register-file and execute block for the single-cycle/pipelined MIPS datapath. It contains:
- a 32×32 register file with two combinational read ports and one synchronous write port;
- an ALU-operation decoder that maps opcode/funct to a 4-bit ALU operation;
- a combinational 32-bit ALU with zero flag.

It sits between instruction decode and data memory. The top level supplies instruction fields, the writeback data and the control bits from the main control unit.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all register-file writes occur on the rising edge.
- rst_n  in  1  reset, active-low, asynchronous (one clock; polarity and synchronicity fixed); clears all 32 registers.
- opcode  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- shamt  in  5  instruction[10:6].
- rs_addr  in  5  read port 1 address.
- rt_addr  in  5  read port 2 address.
- imm16  in  16  instruction[15:0].
- alu_src  in  1  operand B select: 0 = rd_data2, 1 = extended immediate.
- wr_en  in  1  register write enable.
- wr_addr  in  5  write address.
- wr_data  in  32  write data.
- rd_data1  out  32  register[rs_addr].
- rd_data2  out  32  register[rt_addr].
- alu_op  out  4  decoded operation.
- alu_result  out  32  ALU result.
- alu_zero  out  1  1 when alu_result == 0.

## Operation

ALU operation codes:
- AND = 0000, OR = 0001, ADD = 0010, SUB = 0110, SLT = 0111, NOR = 1100.
- SLL = 1000, SRL = 1001, SLTU = 1010, LUI = 1011.

Decoding, R-type (opcode 0x00), by funct:
- 0x20/0x21 → ADD; 0x22/0x23 → SUB.
- 0x24 → AND; 0x25 → OR; 0x27 → NOR.
- 0x2A → SLT; 0x2B → SLTU.
- 0x00 → SLL; 0x02 → SRL.
- Any other funct → ADD.

Decoding, other opcodes:
- Add-type: 0x08, 0x09, all loads 0x20–0x25, all stores 0x28/0x29/0x2B → ADD.
- Branches: 0x04 / 0x05 → SUB.
- Logical immediates: 0x0C → AND; 0x0D → OR.
- Compare immediates: 0x0A → SLT; 0x0B → SLTU.
- 0x0F → LUI.
- Any other opcode → ADD.

Immediate extension:
- Zero-extend imm16 for opcodes 0x0C, 0x0D.
- Sign-extend for all other opcodes.

ALU operands:
- Operand A = rd_data1, except SLL/SRL where A = {27'b0, shamt}.
- Operand B = alu_src ? ext_imm : rd_data2.

ALU results:
- ADD/SUB: 32-bit two's-complement, wrap-around, no overflow detection or trap.
- SLT: signed compare A < B; result is 1 or 0, zero-extended.
- SLTU: unsigned compare A < B; result is 1 or 0, zero-extended.
- SLL: B << A[4:0]. SRL: B >> A[4:0], logical.
- LUI: {B[15:0], 16'b0}.
- NOR: ~(A|B).

Register file:
- Register 0 always reads 0; writes to address 0 are discarded.
- The write occurs when wr_en = 1 at the clk rising edge.
- Reads are combinational from stored state; there is no write-to-read bypass.

## Timing

ALU path:
- Decoder, extender, operand muxes and ALU are purely combinational; alu_result, alu_zero and alu_op are valid the same cycle as their inputs.

Register writes and reads:
- A write takes effect at the rising edge.
- A read of the same address in the cycle of the write returns the old value.
- The new value is visible immediately after the edge.

Reset:
- Reset asserted, asynchronously, clears all registers to 0 immediately; rd_data1 and rd_data2 read 0 while rst_n = 0.
- Writes are ignored while rst_n = 0.
- Reset deassertion mid-program leaves registers at 0; the first write is honoured at the next rising edge with rst_n = 1.

Simultaneous events:
- Reset and write on the same edge: reset wins.

## Structure
- Package mips_exec_pkg holds the alu_op codes, opcode constants and funct constants.
- One sub-module, mips_alu_decoder, performs the opcode/funct → alu_op mapping and the extension-type select.
- Register array and ALU are inline in mips_exec_core.

## Test plan
- Reset: drive rst_n = 0 → all 32 registers read 0 on both ports; rst_n = 1, write 0xDEADBEEF to reg 0 → reg 0 still reads 0.
- addi sequence:
  - addi $16,$0,2: opcode 0x08, rs 0, imm 2, alu_src 1 → alu_result = 2. Write back to reg 16.
  - addi $16,$16,3 → alu_result = 5. Write back → rd_data1 (rs = 16) = 5.
- R-type arithmetic and compares, with regs A = 0xFFFFFFFF, B = 1:
  - add → 0, alu_zero = 1.
  - sub → 0xFFFFFFFE.
  - slt → 1; sltu → 0.
  - nor → 0.
- Shifts and immediates:
  - sll, shamt 4, rt = 0x0000000F → 0xF0; srl, shamt 4, rt = 0x80000000 → 0x08000000.
  - lui imm 0x1234 → 0x12340000.
  - andi imm 0xFFFF on 0xFFFFFFFF → 0x0000FFFF (zero-extended).
- Branch and memory:
  - beq with equal registers → alu_op = SUB, alu_zero = 1.
  - lw with imm 0xFFFC, rs = 8 → result 4 (sign-extended offset).
- Read-during-write: write 7 to reg 3 while reading reg 3 → reads old value before the edge, 7 after.
- Asynchronous reset asserted mid-cycle → regs clear without a clock edge.
